// File: rtl/watchdog_kicker.sv
// watchdog_kicker: heartbeat source for a downstream watchdog.
// A kick is issued at the end of each period only when every monitored task
// has checked in during that period. After Max_Misses consecutive bad periods,
// or when the watchdog reports an error, kicking stops until ipClear.
module watchdog_kicker #(
   parameter int Clk_Frequency  = 50_000_000,
   parameter int Kick_Period_ms = 10,
   parameter int Num_Tasks      = 4,
   parameter int Pulse_Width    = 4,
   parameter int Max_Misses     = 3
) (
   input  logic                 ipClk,
   input  logic                 Reset,
   input  logic                 ipEnable,
   input  logic [Num_Tasks-1:0] ipCheckIn,
   input  logic                 ipWdError,
   input  logic                 ipClear,
   output logic                 opKick,
   output logic [Num_Tasks-1:0] opMissMask,
   output logic [3:0]           opMissCount,
   output logic                 opStarved
);

   localparam int Period_Cycles = (Clk_Frequency / 1000) * Kick_Period_ms;
   localparam int Cnt_W         = (Period_Cycles > 1) ? $clog2(Period_Cycles) : 1;
   localparam int Pls_W         = (Pulse_Width > 1) ? $clog2(Pulse_Width) : 1;

   localparam logic [Cnt_W-1:0]     Period_Load = Cnt_W'(Period_Cycles - 1);
   localparam logic [Pls_W-1:0]     Pulse_Load  = Pls_W'(Pulse_Width - 1);
   localparam logic [Num_Tasks-1:0] All_Ones    = '1;
   localparam logic [3:0]           Miss_Limit  = 4'(Max_Misses);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      KICK   = 2'd1,
      RUN    = 2'd2,
      STARVE = 2'd3
   } state_t;

   state_t               state_q,   state_d;
   logic [Cnt_W-1:0]     period_q,  period_d;
   logic [Pls_W-1:0]     pulse_q,   pulse_d;
   logic [Num_Tasks-1:0] flags_q,   flags_d;
   logic [Num_Tasks-1:0] mask_q,    mask_d;
   logic [3:0]           miss_q,    miss_d;
   logic                 kick_q,    kick_d;
   logic                 starved_q, starved_d;

   logic [Num_Tasks-1:0] eff;
   logic [3:0]           miss_inc;

   // Next-state logic: period/pulse counting, check-in tracking and evaluation.
   always_comb begin
      state_d   = state_q;
      period_d  = period_q;
      pulse_d   = pulse_q;
      flags_d   = flags_q;
      mask_d    = mask_q;
      miss_d    = miss_q;
      // A check-in landing on the evaluation cycle still counts for this period.
      eff       = flags_q | ipCheckIn;
      miss_inc  = (miss_q == 4'd15) ? 4'd15 : (miss_q + 4'd1);

      unique case (state_q)
         IDLE: begin
            if (ipEnable) begin
               // First kick after enable is unconditional.
               state_d  = KICK;
               period_d = Period_Load;
               pulse_d  = Pulse_Load;
            end
         end

         KICK, RUN: begin
            if (ipWdError) begin
               state_d = STARVE;
               flags_d = '0;
            end else if (!ipEnable) begin
               // Miss mask is kept so software can still see the last bad period.
               state_d  = IDLE;
               flags_d  = '0;
               miss_d   = 4'd0;
               period_d = '0;
               pulse_d  = '0;
            end else begin
               flags_d  = eff;
               period_d = period_q - Cnt_W'(1);
               if (state_q == KICK) begin
                  if (pulse_q == '0) begin
                     state_d = RUN;
                  end else begin
                     pulse_d = pulse_q - Pls_W'(1);
                  end
               end
               if (period_q == '0) begin
                  period_d = Period_Load;
                  flags_d  = '0;
                  if (eff == All_Ones) begin
                     state_d = KICK;
                     pulse_d = Pulse_Load;
                     miss_d  = 4'd0;
                  end else begin
                     mask_d  = ~eff;
                     miss_d  = miss_inc;
                     state_d = (miss_inc == Miss_Limit) ? STARVE : RUN;
                  end
               end
            end
         end

         STARVE: begin
            // Sticky: only ipClear leaves, everything else is ignored.
            if (ipClear) begin
               state_d  = IDLE;
               flags_d  = '0;
               miss_d   = 4'd0;
               mask_d   = '0;
               period_d = '0;
               pulse_d  = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered copies of what the next state implies.
      kick_d    = (state_d == KICK);
      starved_d = (state_d == STARVE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge ipClk) begin
      if (Reset) begin
         state_q   <= IDLE;
         period_q  <= '0;
         pulse_q   <= '0;
         flags_q   <= '0;
         mask_q    <= '0;
         miss_q    <= 4'd0;
         kick_q    <= 1'b0;
         starved_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         period_q  <= period_d;
         pulse_q   <= pulse_d;
         flags_q   <= flags_d;
         mask_q    <= mask_d;
         miss_q    <= miss_d;
         kick_q    <= kick_d;
         starved_q <= starved_d;
      end
   end

   assign opKick      = kick_q;
   assign opMissMask  = mask_q;
   assign opMissCount = miss_q;
   assign opStarved   = starved_q;

endmodule

// File: tb/tb_watchdog_kicker.sv
// Directed testbench for watchdog_kicker with a 1000-cycle kick period.
module tb_watchdog_kicker;

   logic       ipClk = 1'b0;
   logic       Reset;
   logic       ipEnable;
   logic [1:0] ipCheckIn;
   logic       ipWdError;
   logic       ipClear;
   logic       opKick;
   logic [1:0] opMissMask;
   logic [3:0] opMissCount;
   logic       opStarved;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int kicks;

   watchdog_kicker #(
      .Clk_Frequency (1_000_000),
      .Kick_Period_ms(1),
      .Num_Tasks     (2),
      .Pulse_Width   (2),
      .Max_Misses    (3)
   ) dut (
      .ipClk      (ipClk),
      .Reset      (Reset),
      .ipEnable   (ipEnable),
      .ipCheckIn  (ipCheckIn),
      .ipWdError  (ipWdError),
      .ipClear    (ipClear),
      .opKick     (opKick),
      .opMissMask (opMissMask),
      .opMissCount(opMissCount),
      .opStarved  (opStarved)
   );

   always #5 ipClk = ~ipClk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock: advance past the edge so registered outputs have settled.
   task automatic step();
      @(posedge ipClk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic pulse_ci(input logic [1:0] m);
      ipCheckIn = m;
      step();
      ipCheckIn = 2'b00;
   endtask

   // Count high opKick cycles until cycle n.
   task automatic count_kicks(input int n, output int k);
      k = 0;
      while (cyc < n) begin
         step();
         if (opKick) k++;
      end
   endtask

   initial begin
      Reset     = 1'b1;
      ipEnable  = 1'b0;
      ipCheckIn = 2'b00;
      ipWdError = 1'b0;
      ipClear   = 1'b0;
      run_to(3);
      chk("rst_kick",    32'(opKick),      32'd0);
      chk("rst_mask",    32'(opMissMask),  32'd0);
      chk("rst_count",   32'(opMissCount), 32'd0);
      chk("rst_starved", 32'(opStarved),   32'd0);
      Reset = 1'b0;

      // Enable and keep both tasks healthy.
      run_to(10);
      ipEnable = 1'b1;
      step();
      chk("en_kick_11", 32'(opKick), 32'd1);
      step();
      chk("en_kick_12", 32'(opKick), 32'd1);
      step();
      chk("en_kick_13", 32'(opKick), 32'd0);
      run_to(20);
      pulse_ci(2'b11);
      run_to(1010);
      chk("pre_eval_1010", 32'(opKick), 32'd0);
      step();
      chk("kick_1011", 32'(opKick), 32'd1);
      step();
      chk("kick_1012", 32'(opKick), 32'd1);
      chk("count_1012", 32'(opMissCount), 32'd0);
      step();
      chk("kick_1013", 32'(opKick), 32'd0);
      run_to(1020);
      pulse_ci(2'b11);
      run_to(2011);
      chk("kick_2011", 32'(opKick), 32'd1);
      step();
      chk("kick_2012", 32'(opKick), 32'd1);
      step();
      chk("kick_2013", 32'(opKick), 32'd0);

      // Task 1 silent for one period.
      run_to(2020);
      pulse_ci(2'b01);
      run_to(3011);
      chk("miss1_kick",  32'(opKick),      32'd0);
      chk("miss1_mask",  32'(opMissMask),  32'd2);
      chk("miss1_count", 32'(opMissCount), 32'd1);
      run_to(3020);
      pulse_ci(2'b11);
      run_to(4011);
      chk("recover_kick",  32'(opKick),      32'd1);
      chk("recover_count", 32'(opMissCount), 32'd0);
      chk("recover_mask",  32'(opMissMask),  32'd2);

      // Three consecutive bad periods lead to starvation.
      run_to(4020);
      pulse_ci(2'b01);
      run_to(5020);
      pulse_ci(2'b01);
      run_to(6011);
      chk("miss2_count",   32'(opMissCount), 32'd2);
      chk("miss2_starved", 32'(opStarved),   32'd0);
      run_to(6020);
      pulse_ci(2'b01);
      run_to(7010);
      chk("pre_starve", 32'(opStarved), 32'd0);
      step();
      chk("starve_flag",  32'(opStarved),   32'd1);
      chk("starve_count", 32'(opMissCount), 32'd3);
      chk("starve_kick",  32'(opKick),      32'd0);
      run_to(7020);
      pulse_ci(2'b11);
      count_kicks(8100, kicks);
      chk("starve_nokicks", 32'(kicks), 32'd0);
      chk("starve_held",    32'(opStarved), 32'd1);

      // Clear with ipEnable still high.
      ipClear = 1'b1;
      step();
      ipClear = 1'b0;
      chk("clr_starved", 32'(opStarved),   32'd0);
      chk("clr_count",   32'(opMissCount), 32'd0);
      chk("clr_mask",    32'(opMissMask),  32'd0);
      chk("clr_kick",    32'(opKick),      32'd0);
      step();
      chk("clr_rekick", 32'(opKick), 32'd1);

      // Task 1 checks in exactly on the evaluation cycle.
      run_to(8110);
      pulse_ci(2'b01);
      run_to(9101);
      pulse_ci(2'b10);
      chk("edge_ci_kick",  32'(opKick),      32'd1);
      chk("edge_ci_count", 32'(opMissCount), 32'd0);

      // Watchdog error during the first pulse cycle.
      ipWdError = 1'b1;
      step();
      ipWdError = 1'b0;
      chk("wderr_kick",    32'(opKick),    32'd0);
      chk("wderr_starved", 32'(opStarved), 32'd1);
      run_to(9110);
      pulse_ci(2'b11);
      count_kicks(10200, kicks);
      chk("wderr_nokicks", 32'(kicks), 32'd0);

      // Reset in the middle of a kick.
      ipClear = 1'b1;
      step();
      ipClear = 1'b0;
      step();
      chk("pre_rst_kick", 32'(opKick), 32'd1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("midrst_kick",    32'(opKick),    32'd0);
      chk("midrst_starved", 32'(opStarved), 32'd0);
      step();
      chk("postrst_kick", 32'(opKick), 32'd1);

      // One miss, then drop ipEnable mid-RUN.
      run_to(10210);
      pulse_ci(2'b01);
      run_to(11204);
      chk("dis_pre_count", 32'(opMissCount), 32'd1);
      run_to(11300);
      ipEnable = 1'b0;
      step();
      chk("dis_count", 32'(opMissCount), 32'd0);
      chk("dis_mask",  32'(opMissMask),  32'd2);
      chk("dis_kick",  32'(opKick),      32'd0);
      ipEnable = 1'b1;
      step();
      chk("reen_kick", 32'(opKick), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/watchdog_kicker.md
# watchdog_kicker

Heartbeat generator that drives the kick input of a downstream watchdog. It kicks only when every monitored task has checked in during the current kick period. After a configurable number of consecutive bad periods it deliberately stops kicking, so the watchdog times out. It sits between the application task logic and the board-level watchdog in the clocking/reset subsystem.

## Interface
- Clk_Frequency, 50_000_000, clock frequency in Hz
- Kick_Period_ms, 10, kick period in ms; Period_Cycles = (Clk_Frequency/1000)*Kick_Period_ms
- Num_Tasks, 4, number of monitored tasks (1..16)
- Pulse_Width, 4, opKick high time in cycles (1 ≤ Pulse_Width < Period_Cycles)
- Max_Misses, 3, consecutive missed periods before starving (1..15)

Ports:
- ipClk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- ipEnable  input  1  level; start/run kicking
- ipCheckIn  input  Num_Tasks  per-task check-in strobes (any high cycle counts)
- ipWdError  input  1  error output of the watchdog being kicked
- ipClear  input  1  single-cycle; leave STARVE
- opKick  output  1  registered kick pulse
- opMissMask  output  Num_Tasks  tasks absent in the last evaluated bad period
- opMissCount  output  4  consecutive bad periods
- opStarved  output  1  high in STARVE

## Operation
- States:
  - IDLE: entered on reset; waits for ipEnable.
  - KICK: drives the pulse; the period counter keeps running.
  - RUN: counts the period; no pulse.
  - STARVE: sticky; no kicks.
- Reset: state IDLE. opKick=0, opMissMask=0, opMissCount=0, opStarved=0. Check-in flags=0. Counters=0.
- Per-task sticky flags: flag[i] is set by ipCheckIn[i]=1 in any cycle in RUN or KICK. Flags are cleared at each evaluation.
- IDLE→KICK when ipEnable=1. This kick is unconditional; the period counter loads Period_Cycles-1.
- Period counter decrements every cycle in RUN/KICK. At Count==0 (the evaluation cycle):
  - Reload Period_Cycles-1.
  - Compute eff = flags | ipCheckIn, so a same-cycle check-in counts toward the current period.
  - If eff is all ones → KICK and opMissCount←0. opMissMask is left unchanged.
  - Else → opMissMask←~eff and opMissCount←opMissCount+1.
    - If the new count equals Max_Misses → STARVE.
    - Otherwise stay in RUN with no kick.
  - All flags cleared.
- KICK lasts Pulse_Width cycles, then → RUN. Check-ins during KICK after the evaluation cycle count toward the new period.
- Priority, highest first: Reset > ipClear (STARVE only) > ipWdError > ipEnable=0 > evaluation.
  - ipWdError=1 in RUN/KICK → STARVE next cycle; opKick drops the same edge.
  - ipEnable=0 in RUN/KICK → IDLE. Flags, opMissCount and counters are cleared; opMissMask is held.
  - ipClear in STARVE → IDLE. Flags, opMissCount and opMissMask are cleared. ipClear in any other state is ignored.
  - In STARVE, ipEnable, ipCheckIn and ipWdError are ignored.
- opMissCount saturates at 15 (it cannot exceed Max_Misses anyway).
- Counter width: $clog2(Period_Cycles).

## Timing
- All outputs are registered.
- Evaluation at cycle T → opKick=1 on cycles T+1..T+Pulse_Width. Steady-state kicks are exactly Period_Cycles apart.
- ipEnable rises at cycle E → opKick=1 from E+1.
- opMissMask and opMissCount update at T+1. opStarved rises at T+1 for a Max_Misses starve, or one cycle after ipWdError.
- Check-in pulses of 1 cycle are sufficient; no edge detection is applied.
- The first evaluation occurs Period_Cycles cycles after the initial kick's start-of-period load.

## Test plan
Common configuration: Clk_Frequency=1_000_000, Kick_Period_ms=1 (1000 cycles), Num_Tasks=2, Pulse_Width=2, Max_Misses=3.

- Reset then ipEnable=1 at cycle 10; strobe both tasks every period → opKick high at cycles 11–12, 1011–1012, 2011–2012. opMissCount stays 0.
- Task 1 silent for one period, task 0 OK → no kick at that evaluation; opMissMask=2'b10, opMissCount=1. Both tasks return next period → kick resumes and opMissCount=0.
- Task 1 silent for 3 consecutive periods → opStarved=1 one cycle after the 3rd evaluation, opMissCount=3, no further kicks. ipClear → IDLE with outputs cleared; ipEnable still high → kick the next cycle.
- ipCheckIn[1] pulses exactly on the evaluation cycle (task 0 already flagged) → counted as good; kick issued.
- ipWdError=1 mid-KICK (pulse cycle 1) → opKick=0 on the next cycle, opStarved=1. Further check-ins produce no kicks.
- Reset asserted mid-KICK, and separately ipEnable dropped mid-RUN → Reset: all outputs 0 next cycle. ipEnable low: IDLE and opMissCount=0 next cycle. Re-enable gives an immediate kick.
